// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage behind the ALU. Accepts one LOAD or STORE at a time (the effective
//   address is already computed), runs a single req/ack bus transaction for it and
//   returns either a sign/zero-extended load value or a completion for the store.
//   Misaligned accesses, illegal funct3 codes and bus timeouts are reported as faults
//   with the done pulse.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   en                    issue strobe, only looked at while idle
//   opcode, func          instruction opcode and funct3
//   addr, storeData       effective address and rs2 value for stores
//   busy                  high whenever an op is in flight
//   done                  one-cycle completion pulse, fault is valid with it
//   rwLsuEn               one-cycle writeback enable for successful loads
//   loadData              extended load result, held until the next successful load
//   fault                 00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
//   memReq, memWe         bus request (held for the whole request phase), write flag
//   memAddr               word-aligned bus address
//   memWData, memWStrb    lane-replicated write data and byte enables (0 on reads)
//   memAck, memRData      bus completion and read data valid in the same cycle

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic        rwLsuEn,
    output logic [31:0] loadData,
    output logic [1:0]  fault,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memWStrb,
    input  logic        memAck,
    input  logic [31:0] memRData
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state;
    state_t        nextState;

    logic          isLoadOp;
    logic          isStoreOp;
    logic          issue;
    logic          legalFunc;
    logic          misaligned;
    logic [1:0]    issueFault;
    logic          timeoutHit;
    logic [CW-1:0] reqCount;

    logic          opIsLoad;
    logic [2:0]    opFunc;
    logic [1:0]    opLane;

    logic [31:0]   storeWData;
    logic [3:0]    storeStrb;
    logic [7:0]    laneByte;
    logic [15:0]   laneHalf;
    logic [31:0]   loadExt;

    logic          unusedOpcodeBits;

    // The low opcode bits are always 2'b11 for these instructions and carry no information.
    assign unusedOpcodeBits = &{1'b0, opcode[1:0]};

    assign isLoadOp  = (opcode[6:2] == 5'b00000);
    assign isStoreOp = (opcode[6:2] == 5'b01000);
    assign issue     = (state == IDLE) && en && (isLoadOp || isStoreOp);

    assign legalFunc  = isLoadOp ? (func inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                 : (func inside {3'b000, 3'b001, 3'b010});
    assign misaligned = ((func[1:0] == 2'b01) && addr[0]) ||
                        ((func[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    // Illegal funct3 is reported ahead of misalignment.
    assign issueFault = !legalFunc ? 2'b10 : (misaligned ? 2'b01 : 2'b00);

    assign timeoutHit = (reqCount == CW'(TIMEOUT_CYCLES - 1));

    assign busy    = (state != IDLE);
    assign memReq  = (state == REQ);
    assign done    = (state == DONE);
    assign rwLsuEn = (state == DONE) && opIsLoad && (fault == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Faults detected at issue skip the bus entirely; an ack always beats the timeout.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    nextState = (issueFault != 2'b00) ? DONE : REQ;
                end
            end
            REQ: begin
                if (memAck || timeoutHit) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Store lanes are encoded from the live inputs and latched at issue so the bus
    // side stays stable for the whole request phase.
    always_comb begin
        storeWData = storeData;
        storeStrb  = 4'b1111;
        case (func[1:0])
            2'b00: begin
                storeWData = {4{storeData[7:0]}};
                storeStrb  = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                storeWData = {2{storeData[15:0]}};
                storeStrb  = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                storeWData = storeData;
                storeStrb  = 4'b1111;
            end
        endcase
    end

    assign laneByte = memRData[{opLane, 3'b000} +: 8];
    assign laneHalf = memRData[{opLane[1], 4'b0000} +: 16];

    always_comb begin
        loadExt = memRData;
        case (opFunc)
            3'b000:  loadExt = {{24{laneByte[7]}}, laneByte};
            3'b001:  loadExt = {{16{laneHalf[15]}}, laneHalf};
            3'b100:  loadExt = {24'h000000, laneByte};
            3'b101:  loadExt = {16'h0000, laneHalf};
            default: loadExt = memRData;
        endcase
    end

    // Datapath registers; loadData only moves on an acked load, so it becomes visible
    // in the same cycle done rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            opIsLoad <= 1'b0;
            opFunc   <= 3'b000;
            opLane   <= 2'b00;
            reqCount <= '0;
            fault    <= 2'b00;
            loadData <= 32'h0;
            memAddr  <= 32'h0;
            memWData <= 32'h0;
            memWStrb <= 4'b0000;
            memWe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        opIsLoad <= isLoadOp;
                        opFunc   <= func;
                        opLane   <= addr[1:0];
                        reqCount <= '0;
                        fault    <= issueFault;
                        memAddr  <= {addr[31:2], 2'b00};
                        memWe    <= isStoreOp;
                        memWData <= isStoreOp ? storeWData : 32'h0;
                        memWStrb <= isStoreOp ? storeStrb : 4'b0000;
                    end
                end
                REQ: begin
                    reqCount <= reqCount + 1'b1;
                    if (memAck) begin
                        if (opIsLoad) begin
                            loadData <= loadExt;
                        end
                    end else if (timeoutHit) begin
                        fault <= 2'b11;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a transaction-level model. Each op is
//   described once (opcode, funct3, address, store data, bus read data and the request
//   cycle in which the bus acks); the model derives fault, extended load value and store
//   lanes from plain arithmetic and lays out the expected cycle timeline. A forked
//   compare loop checks every cycle on the falling edge; hand-computed literals after
//   each op pin the model.

module tb_load_store_unit;

    localparam int TMO = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk;
    logic        reset;
    logic        en;
    logic [6:0]  opcode;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic        rwLsuEn;
    logic [31:0] loadData;
    logic [1:0]  fault;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memWStrb;
    logic        memAck;
    logic [31:0] memRData;

    // expected per-cycle outputs
    logic        checkEn;
    logic        expBusy;
    logic        expReq;
    logic        expDone;
    logic        expRw;
    logic [31:0] expLoadData;
    logic [1:0]  expFault;
    logic [31:0] expAddr;
    logic        expWe;
    logic [31:0] expWData;
    logic [3:0]  expStrb;

    // what the last op looked like from the outside
    int          obsReqCycles;
    int          obsDoneAt;
    logic        obsRw;
    logic [1:0]  obsFault;
    logic [31:0] obsAddr;
    logic        obsWe;
    logic [31:0] obsWData;
    logic [3:0]  obsStrb;

    int          checks;
    int          errors;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .opcode    (opcode),
        .func      (func),
        .addr      (addr),
        .storeData (storeData),
        .busy      (busy),
        .done      (done),
        .rwLsuEn   (rwLsuEn),
        .loadData  (loadData),
        .fault     (fault),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memWStrb  (memWStrb),
        .memAck    (memAck),
        .memRData  (memRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model of one op: fault at issue, extended load value, store lanes.
    task automatic modelOp(input logic [6:0] op, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           output bit isLd, output logic [1:0] flt, output logic [31:0] ld,
                           output logic [31:0] ba, output logic we,
                           output logic [31:0] wd, output logic [3:0] strb);
        int lane;
        int size;
        bit legal;
        bit misal;
        logic [31:0] v;
        isLd  = (op[6:2] == 5'b00000);
        lane  = int'(a & 32'd3);
        size  = int'(f) % 4;
        legal = isLd ? (f == 0 || f == 1 || f == 2 || f == 4 || f == 5) : (f <= 2);
        misal = (size == 1 && lane % 2 != 0) || (size == 2 && lane != 0);
        flt   = !legal ? 2'b10 : (misal ? 2'b01 : 2'b00);
        ba    = a - 32'(lane);
        we    = !isLd;
        case (size)
            0: begin
                v = (rd >> (8 * lane)) & 32'hFF;
                if (f < 4 && v >= 128) v = v + 32'hFFFFFF00;
                wd   = (sd & 32'hFF) * 32'h01010101;
                strb = 4'(1 << lane);
            end
            1: begin
                v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
                if (f < 4 && v >= 32768) v = v + 32'hFFFF0000;
                wd   = (sd & 32'hFFFF) * 32'h00010001;
                strb = (lane >= 2) ? 4'd12 : 4'd3;
            end
            default: begin
                v    = rd;
                wd   = sd;
                strb = 4'd15;
            end
        endcase
        if (isLd) strb = 4'd0;
        ld = v;
    endtask

    task automatic observe(input int off);
        if (memReq) begin
            if (obsReqCycles == 0) begin
                obsAddr  = memAddr;
                obsWe    = memWe;
                obsWData = memWData;
                obsStrb  = memWStrb;
            end
            obsReqCycles++;
        end
        if (done && obsDoneAt == 0) begin
            obsDoneAt = off;
            obsFault  = fault;
        end
        if (rwLsuEn) obsRw = 1'b1;
    endtask

    // Issue one op in the current idle cycle and walk it to completion. ackAt is the
    // request cycle (1-based) in which the bus acks, 0 for never. busyEn keeps a valid
    // LW on the inputs while the op is in flight; it must be ignored.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd,
                                 input int ackAt, input bit busyEn);
        bit          isLd;
        logic [1:0]  mf;
        logic [31:0] ml;
        logic [31:0] ma;
        logic        mwe;
        logic [31:0] mwd;
        logic [3:0]  ms;
        bit          acked;
        int          off;
        modelOp(op, f, a, sd, rd, isLd, mf, ml, ma, mwe, mwd, ms);
        obsReqCycles = 0;
        obsDoneAt    = 0;
        obsRw        = 1'b0;
        obsFault     = 2'b00;
        obsAddr      = 32'h0;
        obsWe        = 1'b0;
        obsWData     = 32'h0;
        obsStrb      = 4'h0;

        en        = 1'b1;
        opcode    = op;
        func      = f;
        addr      = a;
        storeData = sd;
        @(posedge clk); #1;
        off = 1;
        en = busyEn;
        if (busyEn) begin
            opcode = OP_LOAD;
            func   = 3'b010;
            addr   = 32'h0;
        end

        if (mf == 2'b00) begin
            acked = 1'b0;
            for (int k = 1; k <= TMO && !acked; k++) begin
                expBusy  = 1'b1;
                expReq   = 1'b1;
                expDone  = 1'b0;
                expRw    = 1'b0;
                expAddr  = ma;
                expWe    = mwe;
                expWData = mwd;
                expStrb  = ms;
                memAck   = (k == ackAt);
                memRData = (k == ackAt) ? rd : ~rd;
                acked    = (k == ackAt);
                observe(off);
                @(posedge clk); #1;
                off++;
                memAck = 1'b0;
            end
            if (!acked) mf = 2'b11;
        end

        en       = 1'b0;
        expBusy  = 1'b1;
        expReq   = 1'b0;
        expDone  = 1'b1;
        expFault = mf;
        expRw    = isLd && (mf == 2'b00);
        if (isLd && mf == 2'b00) expLoadData = ml;
        observe(off);
        @(posedge clk); #1;
        off++;

        expBusy = 1'b0;
        expDone = 1'b0;
        expRw   = 1'b0;
        expReq  = 1'b0;
        observe(off);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        checkEn     = 1'b0;
        reset       = 1'b1;
        en          = 1'b0;
        opcode      = 7'h0;
        func        = 3'h0;
        addr        = 32'h0;
        storeData   = 32'h0;
        memAck      = 1'b0;
        memRData    = 32'h0;
        expBusy     = 1'b0;
        expReq      = 1'b0;
        expDone     = 1'b0;
        expRw       = 1'b0;
        expLoadData = 32'h0;
        expFault    = 2'b00;
        expAddr     = 32'h0;
        expWe       = 1'b0;
        expWData    = 32'h0;
        expStrb     = 4'h0;

        fork
            forever begin
                @(negedge clk);
                if (checkEn) begin
                    checkOutput("busy", 32'(busy), 32'(expBusy));
                    checkOutput("memReq", 32'(memReq), 32'(expReq));
                    checkOutput("done", 32'(done), 32'(expDone));
                    checkOutput("rwLsuEn", 32'(rwLsuEn), 32'(expRw));
                    checkOutput("loadData", loadData, expLoadData);
                    if (expReq) begin
                        checkOutput("memAddr", memAddr, expAddr);
                        checkOutput("memWe", 32'(memWe), 32'(expWe));
                        checkOutput("memWStrb", 32'(memWStrb), 32'(expStrb));
                        if (expWe) checkOutput("memWData", memWData, expWData);
                    end
                    if (expDone) checkOutput("fault", 32'(fault), 32'(expFault));
                end
            end
        join_none

        @(posedge clk); #1;
        checkEn = 1'b1;
        checkOutput("rstFault", 32'(fault), 32'h0);
        checkOutput("rstMemAddr", memAddr, 32'h0);
        checkOutput("rstMemWData", memWData, 32'h0);
        checkOutput("rstMemWStrb", 32'(memWStrb), 32'h0);
        checkOutput("rstMemWe", 32'(memWe), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(OP_LOAD, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
        checkOutput("lwDoneAt", 32'(obsDoneAt), 32'd2);
        checkOutput("lwRw", 32'(obsRw), 32'd1);
        checkOutput("lwFault", 32'(obsFault), 32'd0);
        checkOutput("lwData", loadData, 32'hDEADBEEF);

        applyStimulus(OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
        checkOutput("lbData", loadData, 32'hFFFFFF80);

        applyStimulus(OP_LOAD, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
        checkOutput("lbuData", loadData, 32'h00000080);

        applyStimulus(OP_STORE, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 1'b1);
        checkOutput("shAddr", obsAddr, 32'h200);
        checkOutput("shStrb", 32'(obsStrb), 32'hC);
        checkOutput("shWData", obsWData, 32'hABCDABCD);
        checkOutput("shWe", 32'(obsWe), 32'd1);
        checkOutput("shRw", 32'(obsRw), 32'd0);
        checkOutput("shDoneAt", 32'(obsDoneAt), 32'd3);
        checkOutput("shHeld", loadData, 32'h00000080);

        applyStimulus(OP_LOAD, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1'b0);
        checkOutput("misReq", 32'(obsReqCycles), 32'd0);
        checkOutput("misDoneAt", 32'(obsDoneAt), 32'd1);
        checkOutput("misFault", 32'(obsFault), 32'd1);

        applyStimulus(OP_STORE, 3'b011, 32'h100, 32'h55, 32'h0, 1, 1'b0);
        checkOutput("illFault", 32'(obsFault), 32'd2);
        checkOutput("illDoneAt", 32'(obsDoneAt), 32'd1);

        applyStimulus(OP_LOAD, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 0, 1'b0);
        checkOutput("tmoReq", 32'(obsReqCycles), 32'd4);
        checkOutput("tmoFault", 32'(obsFault), 32'd3);
        checkOutput("tmoDoneAt", 32'(obsDoneAt), 32'd5);
        checkOutput("tmoHeld", loadData, 32'h00000080);

        applyStimulus(OP_LOAD, 3'b010, 32'h300, 32'h0, 32'h11223344, 4, 1'b0);
        checkOutput("lateReq", 32'(obsReqCycles), 32'd4);
        checkOutput("lateFault", 32'(obsFault), 32'd0);
        checkOutput("lateData", loadData, 32'h11223344);

        applyStimulus(OP_LOAD, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1, 1'b0);
        checkOutput("lhData", loadData, 32'hFFFF8001);

        applyStimulus(OP_LOAD, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 1, 1'b0);
        checkOutput("lhuData", loadData, 32'h0000F00D);

        applyStimulus(OP_STORE, 3'b000, 32'h41, 32'h000000A5, 32'h0, 1, 1'b0);
        checkOutput("sbStrb", 32'(obsStrb), 32'h2);
        checkOutput("sbWData", obsWData, 32'hA5A5A5A5);

        applyStimulus(OP_STORE, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 3, 1'b1);
        checkOutput("swStrb", 32'(obsStrb), 32'hF);
        checkOutput("swDoneAt", 32'(obsDoneAt), 32'd4);

        applyStimulus(OP_LOAD, 3'b111, 32'h101, 32'h0, 32'h0, 1, 1'b0);
        checkOutput("prioFault", 32'(obsFault), 32'd2);

        applyStimulus(OP_STORE, 3'b010, 32'h102, 32'h1, 32'h0, 1, 1'b0);
        checkOutput("swMisFault", 32'(obsFault), 32'd1);

        applyStimulus(OP_LOAD, 3'b110, 32'h100, 32'h0, 32'h0, 1, 1'b0);
        checkOutput("ldIllFault", 32'(obsFault), 32'd2);

        applyStimulus(OP_LOAD, 3'b001, 32'h103, 32'h0, 32'h0, 1, 1'b0);
        checkOutput("lhMisFault", 32'(obsFault), 32'd1);
        checkOutput("faultHeld", loadData, 32'h0000F00D);

        // non-memory opcode must not start anything
        en     = 1'b1;
        opcode = 7'b0110011;
        func   = 3'b010;
        addr   = 32'h100;
        @(posedge clk); #1;
        en = 1'b0;
        checkOutput("ignBusy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // reset in the middle of a request phase abandons the op
        en       = 1'b1;
        opcode   = OP_LOAD;
        func     = 3'b010;
        addr     = 32'h500;
        @(posedge clk); #1;
        en       = 1'b0;
        expBusy  = 1'b1;
        expReq   = 1'b1;
        expAddr  = 32'h500;
        expWe    = 1'b0;
        expStrb  = 4'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        expBusy     = 1'b0;
        expReq      = 1'b0;
        expLoadData = 32'h0;
        checkOutput("rstMidReq", 32'(memReq), 32'd0);
        checkOutput("rstMidData", loadData, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstNoDone", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
